serial_tx_controller: RTL and testbench
=======================================

# serial_tx_controller

Sequencer for the serial output path of the IO unit. Accepts byte write strobes from the IO unit (committed stores to the serial address), buffers them in a small FIFO and serialises each byte onto a UART line (8N1, LSB first) at a fixed baud divisor. Exposes occupancy and overflow status so the IO unit can return them on reads of the serial status address.

## Interface
- DEPTH, 16, FIFO entries; power of two, >= 2
- CLKS_PER_BIT, 868, clock cycles per UART bit; >= 2
- DATA_WIDTH, 8, byte width; equals SerialDataPath width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- serialWE  in  1  write strobe from IO unit, one byte per asserted cycle
- serialWriteData  in  DATA_WIDTH  byte to enqueue, sampled when serialWE=1
- clearOverflow  in  1  clears the overflow flag
- fifoCount  out  $clog2(DEPTH+1)  bytes currently queued, excluding the byte being shifted
- fifoFull  out  1  fifoCount == DEPTH
- txBusy  out  1  1 whenever state != IDLE
- overflow  out  1  sticky; set when a write is dropped
- txd  out  1  UART line, idle high

## Operation
- FIFO: circular buffer, read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH; count register tracks occupancy.
- Push: serialWE=1 and (not full, or a pop occurs the same cycle) -> byte written at write pointer, pointer increments.
- Drop: serialWE=1, full, no pop that cycle -> byte discarded, pointers unchanged, overflow <= 1.
- Pop and push in the same cycle: count unchanged, both pointers advance.
- Overflow: set has priority over clearOverflow in the same cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If count > 0: pop head into shift register, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: txd = shift[bitIndex] for CLKS_PER_BIT cycles each; after bit DATA_WIDTH-1, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. On its last cycle: if count > 0, pop and go directly to START (back-to-back frames); else go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state or bit change; bit index is $clog2(DATA_WIDTH) bits wide.
- A popped byte no longer counts in fifoCount; it lives only in the shift register.

## Timing
- Reset (rst=0, async): state=IDLE, txd=1, txBusy=0, fifoCount=0, fifoFull=0, overflow=0, pointers=0. A frame in progress is aborted: txd returns high immediately and queued bytes are discarded.
- A write at edge N to an empty FIFO while IDLE: fifoCount=1 after N, pop at N+1, state=START and txd=0 after N+1.
- Frame length: exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles, from txd falling to the end of the stop bit.
- Back-to-back frames have no extra idle cycle between the stop bit and the next start bit.
- Status outputs are registered, valid the cycle after the causing edge. No combinational path from serialWE to any output.

## Test plan
- Reset and idle: hold rst=0 for 3 cycles, then release -> txd=1, txBusy=0, fifoCount=0, overflow=0; these stay stable for 50 cycles with no writes.
- Single byte, CLKS_PER_BIT=4: write 0xA5 -> txd falls 2 edges after the write and carries 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total). fifoCount goes 1 -> 0 at the pop. txBusy deasserts after the stop bit.
- Burst, DEPTH=4, CLKS_PER_BIT=4: write 0x01..0x05 on consecutive cycles -> 0x01 is popped, the other four are queued with no overflow, and five frames go out with no idle gap between them. A sixth write issued while fifoCount=4 -> dropped and overflow=1.
- Simultaneous push and pop when full: time a write on the STOP-to-START pop cycle with fifoCount=4 -> accepted, fifoCount stays 4, overflow stays 0, and byte order is preserved.
- Overflow clear and priority: clearOverflow=1 alone -> overflow=0. clearOverflow=1 in the same cycle as a dropped write -> overflow=1.
- Reset mid-frame: assert rst=0 during DATA bit 3 with 2 bytes queued -> txd=1 immediately and fifoCount=0. After release, no frame is sent until a new write arrives.

Source files
------------

// File: rtl/serial_tx_controller.sv
// serial_tx_controller: byte FIFO feeding an 8N1 UART transmitter (LSB first).
// Status (count, full, busy, overflow) and the line itself come straight from
// registers, so nothing on the outputs depends combinationally on serialWE.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | shifting data bits, CLKS_PER_BIT cycles per bit
// STOP  | stop bit (high); last cycle may pop the next byte for a back-to-back frame
module serial_tx_controller #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         serialWE,
  input  logic [DATA_WIDTH-1:0]        serialWriteData,
  input  logic                         clearOverflow,
  output logic [$clog2(DEPTH+1)-1:0]   fifoCount,
  output logic                         fifoFull,
  output logic                         txBusy,
  output logic                         overflow,
  output logic                         txd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int KW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                r_state, w_state_nxt;
  logic [KW-1:0]         r_baud, w_baud_nxt;
  logic [BW-1:0]         r_bit, w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_txd, w_txd_nxt;
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_pop, w_push, w_drop, w_full, w_baud_last, w_have_data;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_have_data = (r_count != '0);
  assign w_baud_last = (r_baud == KW'(CLKS_PER_BIT-1));
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign w_push      = serialWE && (!w_full || w_pop);
  assign w_drop      = serialWE && w_full && !w_pop;

  assign fifoCount = r_count;
  assign fifoFull  = w_full;
  assign txBusy    = (r_state != IDLE);
  assign overflow  = r_overflow;
  assign txd       = r_txd;

  // Next-state, baud/bit counters, pop decision and the registered line value.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + KW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        if (w_have_data) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          if (r_bit == BW'(DATA_WIDTH-1)) w_state_nxt = STOP;
          else                            w_bit_nxt   = r_bit + BW'(1);
        end
      end
      STOP: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          if (w_have_data) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_pop) w_shift_nxt = r_mem[r_rd_ptr];
    case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[w_bit_nxt];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  // Transmitter state register; reset aborts any frame and forces the line high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  // FIFO pointers, occupancy and sticky overflow (a drop beats a clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)             r_overflow <= 1'b1;
      else if (clearOverflow) r_overflow <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= serialWriteData;
  end

endmodule

// File: tb/tb_serial_tx_controller.sv
// Bench for serial_tx_controller (DEPTH=4, CLKS_PER_BIT=4). A frame-level model
// (byte queue plus a position counter within the current 10-bit frame) predicts
// every output each cycle; tables and hand sequences add explicit expectations.
module tb_serial_tx_controller;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int FRAME = (DW+2)*CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          serialWE;
  logic [DW-1:0] serialWriteData;
  logic          clearOverflow;
  logic [CW-1:0] fifoCount;
  logic          fifoFull, txBusy, overflow, txd;

  serial_tx_controller #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .serialWE(serialWE), .serialWriteData(serialWriteData),
    .clearOverflow(clearOverflow), .fifoCount(fifoCount), .fifoFull(fifoFull),
    .txBusy(txBusy), .overflow(overflow), .txd(txd));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: queued bytes, byte in flight, position within its frame (-1 = idle).
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  int         m_t;
  logic       m_ovf;

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       clr;
    int         cnt;
    logic       full;
    logic       ovf;
    logic       busy;
    logic       txd;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_line();
    if (m_t < 0)            return 1;
    if (m_t < CPB)          return 0;
    if (m_t < (DW+1)*CPB)   return int'(m_cur[(m_t-CPB)/CPB]);
    return 1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_t   = -1;
    m_cur = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic we, input logic [7:0] d, input logic clr);
    int sz;
    bit pop, dropped;
    sz  = m_q.size();
    pop = (sz > 0) && (m_t < 0 || m_t == FRAME-1);
    if (pop) begin
      m_cur = m_q.pop_front();
      m_t   = 0;
    end else if (m_t >= 0) begin
      m_t = (m_t == FRAME-1) ? -1 : m_t + 1;
    end
    dropped = we && (sz == DEPTH) && !pop;
    if (we && !dropped) m_q.push_back(d);
    if (dropped)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_model();
    chk("model_txd",   int'(txd),       m_line());
    chk("model_count", int'(fifoCount), m_q.size());
    chk("model_full",  int'(fifoFull),  int'(m_q.size() == DEPTH));
    chk("model_busy",  int'(txBusy),    int'(m_t >= 0));
    chk("model_ovf",   int'(overflow),  int'(m_ovf));
  endtask

  // One clock: drive at the negedge, model follows the posedge, check at next negedge.
  task automatic tick(input logic we, input logic [7:0] d, input logic clr);
    serialWE        = we;
    serialWriteData = d;
    clearOverflow   = clr;
    @(posedge clk);
    model_step(we, d, clr);
    @(negedge clk);
    serialWE      = 1'b0;
    clearOverflow = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    serialWE      = 1'b0;
    clearOverflow = 1'b0;
    rst           = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_txd",   int'(txd),       1);
    chk("rst_busy",  int'(txBusy),    0);
    chk("rst_count", int'(fifoCount), 0);
    chk("rst_ovf",   int'(overflow),  0);
    rst = 1'b1;
  endtask

  initial begin
    int bits[10];
    int guard;
    bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 8'h01, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 8'h02, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 8'h03, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 8'h04, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 8'h05, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'h06, 1'b0, 4, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 8'h07, 1'b1, 4, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 4, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b0};

    rst             = 1'b0;
    serialWE        = 1'b0;
    serialWriteData = '0;
    clearOverflow   = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset and idle stability.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      chk("idle_txd",  int'(txd),    1);
      chk("idle_busy", int'(txBusy), 0);
    end

    // Burst, drop, clear and set-beats-clear.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].we, tbl[i].d, tbl[i].clr);
      chk($sformatf("vec%0d_count", i), int'(fifoCount), tbl[i].cnt);
      chk($sformatf("vec%0d_full", i),  int'(fifoFull),  int'(tbl[i].full));
      chk($sformatf("vec%0d_ovf", i),   int'(overflow),  int'(tbl[i].ovf));
      chk($sformatf("vec%0d_busy", i),  int'(txBusy),    int'(tbl[i].busy));
      chk($sformatf("vec%0d_txd", i),   int'(txd),       int'(tbl[i].txd));
    end
    repeat (5*FRAME + 10) tick(1'b0, 8'h00, 1'b0);

    // Single byte 0xA5: exact line waveform.
    do_reset();
    tick(1'b1, 8'hA5, 1'b0);
    chk("single_count_write", int'(fifoCount), 1);
    chk("single_txd_write",   int'(txd),       1);
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      chk($sformatf("single_bit%0d", i), int'(txd), bits[i/CPB]);
      if (i == 0) chk("single_count_pop", int'(fifoCount), 0);
    end
    chk("single_busy_stop", int'(txBusy), 1);
    tick(1'b0, 8'h00, 1'b0);
    chk("single_busy_end", int'(txBusy), 0);

    // Push on the stop-to-start pop cycle while full.
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h11 + 8'(i), 1'b0);
    guard = 0;
    while (m_t != FRAME-1 && guard < 2*FRAME) begin
      tick(1'b0, 8'h00, 1'b0);
      guard++;
    end
    chk("pushpop_reach_stop", int'(fifoCount), 4);
    tick(1'b1, 8'h16, 1'b0);
    chk("pushpop_count", int'(fifoCount), 4);
    chk("pushpop_ovf",   int'(overflow),  0);
    chk("pushpop_txd",   int'(txd),       0);
    repeat (5*FRAME + 10) tick(1'b0, 8'h00, 1'b0);

    // Reset during data bit 3 with two bytes queued.
    do_reset();
    tick(1'b1, 8'hC3, 1'b0);
    tick(1'b1, 8'h3C, 1'b0);
    tick(1'b1, 8'h5A, 1'b0);
    guard = 0;
    while (m_t != 4*CPB+1 && guard < 2*FRAME) begin
      tick(1'b0, 8'h00, 1'b0);
      guard++;
    end
    chk("mid_count_before", int'(fifoCount), 2);
    chk("mid_txd_before",   int'(txd),       0);
    #2 rst = 1'b0;
    #1;
    chk("mid_txd_async",   int'(txd),       1);
    chk("mid_count_async", int'(fifoCount), 0);
    chk("mid_busy_async",  int'(txBusy),    0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      chk("mid_quiet_busy", int'(txBusy), 0);
    end
    tick(1'b1, 8'h81, 1'b0);
    repeat (FRAME + 5) tick(1'b0, 8'h00, 1'b0);

    // Randomized traffic at several write densities, checked by the model.
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      int pct;
      pct = (seg == 0) ? 2 : (seg == 1) ? 5 : (seg == 2) ? 10 :
            (seg == 3) ? 30 : (seg == 4) ? 60 : 3;
      for (int i = 0; i < 500; i++) begin
        tick(($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0,
             8'($urandom),
             ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
